// File: rtl/ecpa_pkg.sv
// Shared definitions for the ECPA field-arithmetic blocks.
package ecpa_pkg;

    localparam int FIELD_W = 256;

    typedef logic [FIELD_W-1:0] field_t;

    typedef enum logic [1:0] {
        INV_IDLE = 2'd0,
        INV_RUN  = 2'd1,
        INV_DONE = 2'd2
    } inv_state_t;

endpackage

// File: rtl/mod_half.sv
// Combinational modular halving: y = x/2 mod m for odd m and x < m.
// Odd x is made even by adding m first; the W+1-bit sum keeps the carry,
// which lands in the top result bit after the shift.
module mod_half
    import ecpa_pkg::*;
#(
    parameter int W = FIELD_W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] m,
    output logic [W-1:0] y
);

    logic [W:0] addend_s;
    logic [W:0] sum_s;

    assign addend_s = x[0] ? {1'b0, m} : {(W+1){1'b0}};
    assign sum_s    = {1'b0, x} + addend_s;
    assign y        = W'(sum_s >> 1);

endmodule

// File: rtl/modular_inversion.sv
// Modular inverse p = a^-1 mod m (odd m) by the binary extended Euclidean
// algorithm. Invariants kept throughout RUN: x1*a == u and x2*a == v (mod m),
// with x1, x2 in [0, m). Uses the same start/ready handshake as the
// modular multiplier.
module modular_inversion
    import ecpa_pkg::*;
#(
    parameter int W        = FIELD_W,
    parameter int MAX_ITER = 4*W+4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] m,
    output logic [W-1:0] p,
    output logic         ready,
    output logic         busy,
    output logic         err
);

    localparam int            ITER_W     = $clog2(MAX_ITER + 1);
    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
    localparam logic [W-1:0]  ONE        = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]  ZERO       = {W{1'b0}};

    inv_state_t        state_r, state_s;
    logic [W-1:0]      u_r, u_s, v_r, v_s;
    logic [W-1:0]      x1_r, x1_s, x2_r, x2_s;
    logic [W-1:0]      mr_r, mr_s, p_r, p_s;
    logic [ITER_W-1:0] iter_r, iter_s;
    logic              ready_r, ready_s, busy_r, busy_s, err_r, err_s;

    logic              bad_operand_s;
    logic              u_ge_v_s;
    logic [W-1:0]      sub_a_s, sub_b_s, uv_diff_s;
    logic [W-1:0]      xa_s, xb_s, x_diff_s, x_mod_s;
    logic              x_borrow_s;
    logic [W-1:0]      x1_half_s, x2_half_s;

    assign bad_operand_s = (a == ZERO) || (a >= m) || (m[0] == 1'b0);

    // Single u/v subtractor: larger minus smaller, the compare picks the order.
    assign u_ge_v_s  = (u_r >= v_r);
    assign sub_a_s   = u_ge_v_s ? u_r : v_r;
    assign sub_b_s   = u_ge_v_s ? v_r : u_r;
    assign uv_diff_s = sub_a_s - sub_b_s;

    // Matching coefficient update (x1-x2 or x2-x1) mod m; borrow adds m back.
    assign xa_s                   = u_ge_v_s ? x1_r : x2_r;
    assign xb_s                   = u_ge_v_s ? x2_r : x1_r;
    assign {x_borrow_s, x_diff_s} = {1'b0, xa_s} - {1'b0, xb_s};
    assign x_mod_s                = x_borrow_s ? (x_diff_s + mr_r) : x_diff_s;

    mod_half #(.W(W)) u_half_x1 (.x(x1_r), .m(mr_r), .y(x1_half_s));
    mod_half #(.W(W)) u_half_x2 (.x(x2_r), .m(mr_r), .y(x2_half_s));

    // Next-state and datapath selection; one algorithm step per RUN cycle.
    always_comb begin
        state_s = state_r;
        u_s     = u_r;
        v_s     = v_r;
        x1_s    = x1_r;
        x2_s    = x2_r;
        mr_s    = mr_r;
        iter_s  = iter_r;
        p_s     = p_r;
        ready_s = ready_r;
        busy_s  = busy_r;
        err_s   = err_r;
        case (state_r)
            INV_IDLE, INV_DONE: begin
                if (start) begin
                    u_s     = a;
                    v_s     = m;
                    x1_s    = ONE;
                    x2_s    = ZERO;
                    mr_s    = m;
                    iter_s  = {ITER_W{1'b0}};
                    p_s     = ZERO;
                    ready_s = 1'b0;
                    err_s   = 1'b0;
                    if (bad_operand_s) begin
                        state_s = INV_DONE;
                        ready_s = 1'b1;
                        busy_s  = 1'b0;
                        err_s   = 1'b1;
                    end else begin
                        state_s = INV_RUN;
                        busy_s  = 1'b1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            INV_RUN: begin
                if (u_r == ONE) begin
                    p_s     = x1_r;
                    state_s = INV_DONE;
                    ready_s = 1'b1;
                    busy_s  = 1'b0;
                end else if (v_r == ONE) begin
                    p_s     = x2_r;
                    state_s = INV_DONE;
                    ready_s = 1'b1;
                    busy_s  = 1'b0;
                end else if ((u_r == ZERO) || (v_r == ZERO) || (iter_r == ITER_LIMIT)) begin
                    p_s     = ZERO;
                    err_s   = 1'b1;
                    state_s = INV_DONE;
                    ready_s = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    iter_s = iter_r + ITER_W'(1);
                    if (u_r[0] == 1'b0) begin
                        u_s  = u_r >> 1;
                        x1_s = x1_half_s;
                    end else if (v_r[0] == 1'b0) begin
                        v_s  = v_r >> 1;
                        x2_s = x2_half_s;
                    end else if (u_ge_v_s) begin
                        u_s  = uv_diff_s;
                        x1_s = x_mod_s;
                    end else begin
                        v_s  = uv_diff_s;
                        x2_s = x_mod_s;
                    end
                end
            end
            default: begin
                state_s = INV_IDLE;
                ready_s = 1'b0;
                busy_s  = 1'b0;
                err_s   = 1'b0;
                p_s     = ZERO;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= INV_IDLE;
            u_r     <= ZERO;
            v_r     <= ZERO;
            x1_r    <= ZERO;
            x2_r    <= ZERO;
            mr_r    <= ZERO;
            iter_r  <= {ITER_W{1'b0}};
            p_r     <= ZERO;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            u_r     <= u_s;
            v_r     <= v_s;
            x1_r    <= x1_s;
            x2_r    <= x2_s;
            mr_r    <= mr_s;
            iter_r  <= iter_s;
            p_r     <= p_s;
            ready_r <= ready_s;
            busy_r  <= busy_s;
            err_r   <= err_s;
        end
    end

    assign p     = p_r;
    assign ready = ready_r;
    assign busy  = busy_r;
    assign err   = err_r;

endmodule

// File: tb/tb_modular_inversion.sv
// Self-checking bench for modular_inversion: extended-Euclid reference model,
// per-cycle output comparison while ready, directed corner cases and random ops.
module tb_modular_inversion;

    localparam int W        = 256;
    localparam int MAX_ITER = 4*W+4;
    localparam int SW       = W+4;
    localparam logic [W-1:0] MBIG  = {{248{1'b1}}, 8'h43};
    localparam logic [W-1:0] MHALF = {1'b0, {247{1'b1}}, 8'hA2};

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] a, m, p;
    logic         ready, busy, err;

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] exp_p;
    logic         exp_err;
    bit           exp_valid = 1'b0;

    modular_inversion #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .m(m),
        .p(p), .ready(ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Reference: precondition test, then extended Euclid with quotients.
    function automatic void model_inv(input logic [W-1:0] ai, input logic [W-1:0] mi,
                                      output logic [W-1:0] po, output logic eo);
        logic signed [SW-1:0] r0, r1, t0, t1, q, tmp;
        if (ai == '0 || ai >= mi || mi[0] == 1'b0) begin
            po = '0; eo = 1'b1;
            return;
        end
        r0 = {4'b0, mi}; r1 = {4'b0, ai};
        t0 = '0;         t1 = {{(SW-1){1'b0}}, 1'b1};
        while (r1 != 0) begin
            q   = r0 / r1;
            tmp = r0 - q * r1; r0 = r1; r1 = tmp;
            tmp = t0 - q * t1; t0 = t1; t1 = tmp;
        end
        if (r0 != 1) begin
            po = '0; eo = 1'b1;
        end else begin
            if (t0 < 0) t0 = t0 + $signed({4'b0, mi});
            po = t0[W-1:0]; eo = 1'b0;
        end
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Output compare against the model on every cycle a result is presented.
    always @(negedge clk) begin
        if (!rst && exp_valid && ready) begin
            check("p_vs_model", p, exp_p);
            check("err_vs_model", {{(W-1){1'b0}}, err}, {{(W-1){1'b0}}, exp_err});
            check("busy_while_ready", {{(W-1){1'b0}}, busy}, '0);
        end
    end

    // Drive one start, let the sampling edge pass, then publish the expectation.
    task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] mi);
        logic [W-1:0] pm;
        logic         em;
        start = 1'b1; a = ai; m = mi;
        @(posedge clk); #1;
        model_inv(ai, mi, pm, em);
        exp_p = pm; exp_err = em; exp_valid = 1'b1;
        start = 1'b0;
        a = rand_w(); m = rand_w();
    endtask

    // Wait for ready, latency counted in edges with the sampling edge as 1.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!ready && lat < MAX_ITER + 2) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!ready) begin
            total++; bad++;
            $display("FAIL timeout: ready still %0b after %0d cycles, required 1", ready, lat);
        end
    endtask

    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] mi, output int lat);
        logic [2*W-1:0] prod;
        issue(ai, mi);
        wait_done(lat);
        total++;
        if (lat > MAX_ITER + 2) begin
            bad++;
            $display("FAIL latency_bound: got %0d required <= %0d", lat, MAX_ITER + 2);
        end
        if (ready && !err) begin
            prod = ({{W{1'b0}}, ai} * {{W{1'b0}}, p}) % {{W{1'b0}}, mi};
            check("a_times_p_mod_m", prod[W-1:0], {{(W-1){1'b0}}, 1'b1});
        end
    endtask

    initial begin
        int           lat;
        logic [W-1:0] pm, mm, am, mask, p_first;
        logic         em;

        rst = 1'b1; start = 1'b0; a = '0; m = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_p", p, '0);
        check("reset_ready", {{(W-1){1'b0}}, ready}, '0);
        check("reset_busy", {{(W-1){1'b0}}, busy}, '0);
        check("reset_err", {{(W-1){1'b0}}, err}, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Pin the reference model with hand-computed values.
        model_inv(256'd3, 256'd7, pm, em);
        check("model_3_mod_7", pm, 256'd5);
        model_inv(256'd2, MBIG, pm, em);
        check("model_2_mod_big", pm, MHALF);
        model_inv(256'd6, 256'd15, pm, em);
        check("model_gcd_err", {{(W-1){1'b0}}, em}, 256'd1);

        // Small modulus; ready holds until the next start.
        do_op(256'd3, 256'd7, lat);
        check("inv3_mod7", p, 256'd5);
        repeat (4) @(posedge clk);
        #1;
        check("ready_held", {{(W-1){1'b0}}, ready}, 256'd1);
        check("p_held", p, 256'd5);

        // Full-width modulus.
        do_op(256'd2, MBIG, lat);
        check("inv2_big", p, MHALF);
        do_op(MBIG - 256'd1, MBIG, lat);
        check("inv_mminus1", p, MBIG - 256'd1);

        // Latency corners.
        do_op(256'd1, MBIG, lat);
        check("a1_p", p, 256'd1);
        check("a1_latency", lat, 256'd2);
        do_op(256'd0, 256'd7, lat);
        check("a0_latency", lat, 256'd1);
        check("a0_err", {{(W-1){1'b0}}, err}, 256'd1);
        check("a0_p", p, '0);

        // No inverse / bad modulus.
        do_op(256'd6, 256'd15, lat);
        check("gcd3_err", {{(W-1){1'b0}}, err}, 256'd1);
        check("gcd3_p", p, '0);
        do_op(256'd3, 256'd10, lat);
        check("even_m_err", {{(W-1){1'b0}}, err}, 256'd1);

        // Start while busy is ignored.
        issue(256'd5, MBIG);
        model_inv(256'd5, MBIG, p_first, em);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; a = 256'd7; m = 256'd13;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_ignored_start", {{(W-1){1'b0}}, busy}, 256'd1);
        wait_done(lat);
        check("ignored_start_result", p, p_first);

        // Back-to-back start from DONE: ready drops, new result follows.
        issue(256'd4, 256'd9);
        check("ready_drops", {{(W-1){1'b0}}, ready}, '0);
        wait_done(lat);
        check("b2b_result", p, 256'd7);

        // Reset in the middle of a computation.
        issue(MBIG - 256'd12345, MBIG);
        repeat (4) @(posedge clk);
        #1;
        check("busy_before_rst", {{(W-1){1'b0}}, busy}, 256'd1);
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; exp_valid = 1'b0;
        check("rst_ready", {{(W-1){1'b0}}, ready}, '0);
        check("rst_busy", {{(W-1){1'b0}}, busy}, '0);
        check("rst_err", {{(W-1){1'b0}}, err}, '0);
        check("rst_p", p, '0);
        @(posedge clk); #1;
        check("rst_stays_idle", {{(W-1){1'b0}}, busy}, '0);
        do_op(256'd3, 256'd7, lat);
        check("after_rst", p, 256'd5);

        // Random operations over assorted modulus widths.
        for (int n = 0; n < 40; n++) begin
            mask = '1;
            mask = mask >> (W - $urandom_range(2, W));
            mm = rand_w() & mask;
            mm[0] = 1'b1;
            if (mm < 256'd3) mm = 256'd3;
            am = rand_w() % mm;
            if ($urandom_range(0, 9) == 0) am = mm;
            else if (am == '0) am = 256'd1;
            do_op(am, mm, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
